data_mem_responder_8051: RTL and testbench

DATA_MEM_RESPONDER_8051 -- requirements
Module: data_mem_responder_8051

---
 rtl/data_mem_responder_8051.sv | 124 ++++++++++++
 tb/tb_data_mem_responder_8051.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_8051.sv
// 256x8 direct-memory responder: waited single read/write plus aligned 4-beat line fill.
// Optional even-parity per byte when DMR_PARITY_EN is defined.
module data_mem_responder_8051 #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic       burst,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic [1:0] rbeat,
  output logic       done,
  output logic       busy,
  output logic       perr
);

  // state  | meaning
  // IDLE   | waiting for req; request fields latched on accept
  // WAIT   | access wait states, counter runs down to 0
  // XFER   | one write cycle, one read beat, or four line-fill beats
  // DONE   | done held until requester drops req
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

  localparam logic [3:0] LP_CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit         LP_NO_WAIT  = (WAIT_CYCLES == 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [1:0]  r_beat;
  logic        r_we;
  logic        r_burst;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  w_rd_addr;
  logic        w_wr_commit;

  // Storage is not reset; contents survive rst and start at zero.
  logic [7:0]  r_mem [0:255] = '{default: 8'h00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req) w_state_nxt = LP_NO_WAIT ? S_XFER : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_XFER;
      S_XFER: if (!r_burst || (r_beat == 2'd3)) w_state_nxt = S_DONE;
      S_DONE: if (!req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_beat  <= 2'd0;
      r_we    <= 1'b0;
      r_burst <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: if (req) begin
          r_cnt   <= LP_CNT_LOAD;
          r_beat  <= 2'd0;
          r_we    <= we;
          r_burst <= burst & ~we;
          r_addr  <= addr;
          r_wdata <= wdata;
        end
        S_WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        S_XFER: if (r_burst) r_beat <= r_beat + 2'd1;
        default: ;
      endcase
    end
  end

  // Line-fill beats replace the low two address bits, so they never leave the aligned line.
  assign w_rd_addr   = r_burst ? {r_addr[7:2], r_beat} : r_addr;
  assign w_wr_commit = rst && (r_state == S_XFER) && r_we;

  always_ff @(posedge clk) begin
    if (w_wr_commit) r_mem[r_addr] <= r_wdata;
  end

  always_comb begin
    rvalid = 1'b0;
    rbeat  = 2'd0;
    rdata  = 8'h00;
    done   = (r_state == S_DONE);
    busy   = (r_state != S_IDLE);
    if ((r_state == S_XFER) && !r_we) begin
      rvalid = 1'b1;
      rbeat  = r_beat;
      rdata  = r_mem[w_rd_addr];
    end
  end

`ifdef DMR_PARITY_EN
  logic r_par [0:255] = '{default: 1'b0};

  always @(posedge clk) begin
    if (w_wr_commit) r_par[r_addr] <= ^r_wdata;
  end

  // Test hook: corrupt the stored parity of one byte from a hierarchical reference.
  task automatic flip_parity(input logic [7:0] a);
    r_par[a] = ~r_par[a];
  endtask

  assign perr = rvalid && (r_par[w_rd_addr] != (^r_mem[w_rd_addr]));
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder_8051.sv
// Directed bench for data_mem_responder_8051: one instance with WAIT_CYCLES=2, one with 0.
module tb_data_mem_responder_8051;

  logic       clk = 1'b0;
  logic       rst;
  logic       req2, req0, we, burst;
  logic [7:0] addr, wdata;
  logic [7:0] rdata2, rdata0;
  logic       rvalid2, rvalid0, done2, done0, busy2, busy0, perr2, perr0;
  logic [1:0] rbeat2, rbeat0;

  bit         sel;
  logic [7:0] w_rdata;
  logic       w_rvalid, w_done, w_busy, w_perr;
  logic [1:0] w_rbeat;

  int         n_checks = 0;
  int         n_fail   = 0;

  int         cap_n, cap_lat, cap_done;
  logic [7:0] cap_d [4];
  logic [1:0] cap_b [4];
  logic       cap_perr, cap_busy_all, cap_idle_busy;

  always #5 clk = ~clk;

  data_mem_responder_8051 #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req2), .we(we), .burst(burst), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .rvalid(rvalid2), .rbeat(rbeat2), .done(done2), .busy(busy2), .perr(perr2)
  );

  data_mem_responder_8051 #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .burst(burst), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .rvalid(rvalid0), .rbeat(rbeat0), .done(done0), .busy(busy0), .perr(perr0)
  );

  assign w_rdata  = sel ? rdata0  : rdata2;
  assign w_rvalid = sel ? rvalid0 : rvalid2;
  assign w_rbeat  = sel ? rbeat0  : rbeat2;
  assign w_done   = sel ? done0   : done2;
  assign w_busy   = sel ? busy0   : busy2;
  assign w_perr   = sel ? perr0   : perr2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full handshake on the selected instance; inputs are scrambled right after acceptance.
  task automatic run_txn(input bit s, input logic w, input logic b,
                         input logic [7:0] a, input logic [7:0] d);
    int cyc;
    sel = s;
    @(negedge clk);
    we = w; burst = b; addr = a; wdata = d;
    if (s) req0 = 1'b1; else req2 = 1'b1;
    @(posedge clk);
    #1;
    we = ~w; burst = ~b; addr = ~a; wdata = ~d;
    cap_n = 0; cap_lat = -1; cap_done = -1; cap_perr = 1'b0; cap_busy_all = 1'b1;
    for (int i = 0; i < 4; i++) begin cap_d[i] = 8'h00; cap_b[i] = 2'd0; end
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      cap_busy_all &= w_busy;
      if (w_rvalid) begin
        if (cap_lat < 0) cap_lat = cyc;
        if (cap_n < 4) begin cap_d[cap_n] = w_rdata; cap_b[cap_n] = w_rbeat; end
        cap_n++;
        cap_perr |= w_perr;
      end
      if (w_done) begin cap_done = cyc; break; end
    end
    req0 = 1'b0; req2 = 1'b0;
    @(negedge clk);
    cap_idle_busy = w_busy | w_done;
  endtask

  initial begin
    int ndone, lat, cyc;
    logic [7:0] dat;
    logic [7:0] line [4];
    line[0] = 8'h11; line[1] = 8'h22; line[2] = 8'h33; line[3] = 8'h44;
    rst = 1'b0; req2 = 1'b0; req0 = 1'b0; we = 1'b0; burst = 1'b0; addr = 8'h00; wdata = 8'h00;
    sel = 1'b0;
    #3;
    chk("rst_rvalid", rvalid2, 0);
    chk("rst_done",   done2,   0);
    chk("rst_busy",   busy2,   0);
    chk("rst_rdata",  rdata2,  0);
    chk("rst_rbeat",  rbeat2,  0);
    chk("rst_perr",   perr2,   0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_txn(0, 1, 0, 8'h30, 8'h03);
    chk("wr30_beats", cap_n, 0);
    chk("wr30_done_cyc", cap_done, 4);
    chk("wr30_idle_after", cap_idle_busy, 0);

    run_txn(0, 0, 0, 8'h30, 8'h00);
    chk("rd30_lat", cap_lat, 3);
    chk("rd30_beats", cap_n, 1);
    chk("rd30_data", cap_d[0], 8'h03);
    chk("rd30_rbeat", cap_b[0], 0);
    chk("rd30_done_cyc", cap_done, 4);
    chk("rd30_busy", cap_busy_all, 1);
    chk("rd30_perr", cap_perr, 0);

    for (int i = 0; i < 4; i++) run_txn(0, 1, 0, 8'hFC + 8'(i), line[i]);
    run_txn(0, 0, 1, 8'hFE, 8'h00);
    chk("burst_beats", cap_n, 4);
    chk("burst_lat", cap_lat, 3);
    chk("burst_done_cyc", cap_done, 7);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst_data%0d", i), cap_d[i], line[i]);
      chk($sformatf("burst_rbeat%0d", i), cap_b[i], i);
    end

    run_txn(0, 1, 1, 8'h32, 8'h77);
    chk("wrburst_beats", cap_n, 0);
    run_txn(0, 0, 0, 8'h32, 8'h00);
    chk("rd32_data", cap_d[0], 8'h77);
    chk("rd32_beats", cap_n, 1);

    // req held through DONE for five cycles
    sel = 1'b0;
    @(negedge clk);
    we = 1'b0; burst = 1'b0; addr = 8'h30; req2 = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done2 && cyc < 40);
    chk("hold_done_cyc", cyc, 4);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_done_%0d", k), done2, 1);
    end
    req2 = 1'b0;
    @(negedge clk);
    chk("hold_exit_done", done2, 0);
    chk("hold_exit_busy", busy2, 0);
    repeat (3) @(negedge clk);
    chk("hold_no_retrigger", busy2, 0);

    // req dropped right after acceptance
    @(negedge clk);
    we = 1'b0; burst = 1'b0; addr = 8'h30; req2 = 1'b1;
    @(posedge clk);
    #1 req2 = 1'b0;
    ndone = 0; lat = -1; dat = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rvalid2 && lat < 0) begin lat = c; dat = rdata2; end
      if (done2) ndone++;
    end
    chk("early_drop_lat", lat, 3);
    chk("early_drop_data", dat, 8'h03);
    chk("early_drop_done_cycles", ndone, 1);
    chk("early_drop_idle", busy2, 0);

    // reset during WAIT of a write
    @(negedge clk);
    we = 1'b1; burst = 1'b0; addr = 8'h40; wdata = 8'h55; req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstwait_busy_pre", busy2, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstwait_busy", busy2, 0);
    chk("rstwait_done", done2, 0);
    chk("rstwait_rvalid", rvalid2, 0);
    req2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_txn(0, 0, 0, 8'h40, 8'h00);
    chk("rd40_after_rst", cap_d[0], 8'h00);
    chk("rd40_beats", cap_n, 1);

    // zero wait states
    run_txn(1, 1, 0, 8'h31, 8'h5A);
    chk("w0_wr_done_cyc", cap_done, 2);
    run_txn(1, 0, 0, 8'h31, 8'h00);
    chk("w0_rd_lat", cap_lat, 1);
    chk("w0_rd_data", cap_d[0], 8'h5A);
    chk("w0_rd_done_cyc", cap_done, 2);
    chk("w0_busy", cap_busy_all, 1);
    chk("w0_idle_after", cap_idle_busy, 0);

`ifdef DMR_PARITY_EN
    run_txn(0, 1, 0, 8'h10, 8'hA5);
    @(negedge clk);
    dut.flip_parity(8'h10);
    run_txn(0, 0, 0, 8'h10, 8'h00);
    chk("par_rd10_data", cap_d[0], 8'hA5);
    chk("par_rd10_perr", cap_perr, 1);
    run_txn(0, 0, 0, 8'h11, 8'h00);
    chk("par_rd11_perr", cap_perr, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
